// File: rtl/nf10_axis_pkg.sv
// nf10_axis_pkg: shared widths and lane helpers for the nf10 AXI-Stream upsizer
package nf10_axis_pkg;
   localparam int S_AXIS_DATA_W  = 64;
   localparam int M_AXIS_DATA_W  = 256;
   localparam int S_AXIS_TUSER_W = 128;

   function automatic int ratio(input int s_w, input int m_w);
      return m_w / s_w;
   endfunction

   function automatic int idx_w(input int r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

   function automatic int lane_lo(input int idx, input int lane_w);
      return idx * lane_w;
   endfunction
endpackage

// File: rtl/nf10_axis_out_reg.sv
// nf10_axis_out_reg: output beat register that holds its contents until the sink accepts
module nf10_axis_out_reg #(
   parameter int DATA_W = 256,
   parameter int USER_W = 128
)(
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                load,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [DATA_W/8-1:0] in_strb,
   input  logic [USER_W-1:0]   in_user,
   input  logic                in_last,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic [DATA_W/8-1:0] m_axis_tstrb,
   output logic [USER_W-1:0]   m_axis_tuser,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast
);
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else if (load) begin
         m_axis_tdata  <= in_data;
         m_axis_tstrb  <= in_strb;
         m_axis_tuser  <= in_user;
         m_axis_tlast  <= in_last;
         m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready)
         m_axis_tvalid <= 1'b0;
endmodule

// File: rtl/nf10_axis_dma_upsizer.sv
// nf10_axis_dma_upsizer: packs narrow AXI-Stream beats into wide beats, flushing short tails on tlast
module nf10_axis_dma_upsizer
   import nf10_axis_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = S_AXIS_DATA_W,
   parameter int C_M_AXIS_DATA_WIDTH  = M_AXIS_DATA_W,
   parameter int C_S_AXIS_TUSER_WIDTH = S_AXIS_TUSER_W
)(
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic                             s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,
   output logic [31:0]                      pkt_count
);
   localparam int RATIO = ratio(C_S_AXIS_DATA_WIDTH, C_M_AXIS_DATA_WIDTH);
   localparam int IDX_W = idx_w(RATIO);
   localparam int SB    = C_S_AXIS_DATA_WIDTH / 8;

   logic [IDX_W-1:0]                 idx;
   logic                             sop;
   logic [C_M_AXIS_DATA_WIDTH-1:0]   acc_data, nxt_data;
   logic [C_M_AXIS_DATA_WIDTH/8-1:0] acc_strb, nxt_strb;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]  acc_user, nxt_user;
   logic                             accept, complete;

   assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign complete      = accept && (idx == IDX_W'(RATIO - 1) || s_axis_tlast);

   // Accumulator view including the beat being accepted, so a completing beat loads in one step
   always_comb begin
      nxt_data = acc_data;
      nxt_strb = acc_strb;
      nxt_data[lane_lo(int'(idx), C_S_AXIS_DATA_WIDTH) +: C_S_AXIS_DATA_WIDTH] = s_axis_tdata;
      nxt_strb[lane_lo(int'(idx), SB) +: SB] = s_axis_tstrb;
      nxt_user = sop ? s_axis_tuser : acc_user;
   end

   // tuser survives a mid-packet flush so every output beat of the packet repeats it
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         idx      <= '0;
         sop      <= 1'b1;
         acc_data <= '0;
         acc_strb <= '0;
         acc_user <= '0;
      end else if (accept) begin
         idx      <= complete ? '0 : idx + IDX_W'(1);
         sop      <= complete && s_axis_tlast;
         acc_data <= complete ? '0 : nxt_data;
         acc_strb <= complete ? '0 : nxt_strb;
         acc_user <= nxt_user;
      end

   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn)
         pkt_count <= '0;
      else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
         pkt_count <= pkt_count + 32'd1;

   nf10_axis_out_reg #(
      .DATA_W(C_M_AXIS_DATA_WIDTH),
      .USER_W(C_S_AXIS_TUSER_WIDTH)
   ) u_out_reg (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .load         (complete),
      .in_data      (nxt_data),
      .in_strb      (nxt_strb),
      .in_user      (nxt_user),
      .in_last      (s_axis_tlast),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tstrb (m_axis_tstrb),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast)
   );
endmodule
